// File: rtl/multicycle_alu_pkg.sv
// Shared opcode encodings, FSM state encodings and opcode classification for
// the multi-cycle execute-stage ALU.
package multicycle_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DIV  = 2'd3;

  typedef enum logic [1:0] {
    CLS_SINGLE,
    CLS_MUL,
    CLS_DIV,
    CLS_ILLEGAL
  } op_class_e;

  // Decides which FSM path an accepted opcode takes.
  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_MUL:                      cls = CLS_MUL;
      OP_DIVU, OP_REMU:            cls = CLS_DIV;
      OP_AND, OP_OR, OP_ADD, OP_SRL, OP_SRA,
      OP_SLL, OP_SUB, OP_SLT, OP_SLTU: cls = CLS_SINGLE;
      default:                     cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_iterative_core.sv
// Bit-serial engine shared by MUL (shift-add) and DIVU/REMU (restoring
// division); performs one step per cycle for WIDTH cycles after start.
module alu_iterative_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // acc: partial product / partial remainder
  // x:   multiplicand (shifts left) / divisor (static)
  // y:   multiplier (shifts right) / dividend shifting into quotient
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] x_next, y_next;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             div_mode;
  logic [WIDTH:0]   rem_shift;
  logic             fits;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_next  = acc;
    x_next    = x;
    y_next    = y;
    rem_shift = {acc, y[WIDTH-1]};
    fits      = rem_shift >= {1'b0, x};
    if (div_mode) begin
      acc_next = fits ? rem_shift[WIDTH-1:0] - x : rem_shift[WIDTH-1:0];
      y_next   = {y[WIDTH-2:0], fits};
    end else begin
      acc_next = acc + (y[0] ? x : '0);
      x_next   = x << 1;
      y_next   = y >> 1;
    end
  end

  // cnt numbers the step in progress, so done flags the cycle of the final step;
  // the parent captures acc_next/quo_next on that same edge.
  assign busy     = running;
  assign done     = running && (cnt == CNT_W'(WIDTH));
  assign quo_next = y_next;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running  <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
    end else if (start) begin
      running  <= 1'b1;
      div_mode <= is_div;
      cnt      <= CNT_W'(1);
      acc      <= '0;
      x        <= is_div ? op_b : op_a;
      y        <= is_div ? op_a : op_b;
    end else if (running) begin
      acc <= acc_next;
      x   <= x_next;
      y   <= y_next;
      if (done) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU with valid/ready handshake: single-cycle logic/shift/add ops
// plus iterative MUL/DIVU/REMU; results held registered until taken.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [3:0]       Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Error,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic               accept;
  op_class_e          cls;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_out;
  logic               core_start;
  logic               core_busy;
  logic               core_done;
  logic [WIDTH-1:0]   core_acc;
  logic [WIDTH-1:0]   core_quo;
  logic [WIDTH-1:0]   iter_res;

  assign InReady    = (state == ST_IDLE);
  assign accept     = InValid && InReady;
  assign cls        = op_class(Control);
  assign shamt      = B[SHAMT_W-1:0];
  assign core_start = accept && ((cls == CLS_MUL) || (cls == CLS_DIV));

  always_comb begin
    alu_out = '0;
    case (Control)
      OP_AND:  alu_out = A & B;
      OP_OR:   alu_out = A | B;
      OP_ADD:  alu_out = A + B;
      OP_SUB:  alu_out = A - B;
      OP_SRL:  alu_out = A >> shamt;
      OP_SRA:  alu_out = WIDTH'($signed(A) >>> shamt);
      OP_SLL:  alu_out = A << shamt;
      OP_SLT:  alu_out = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_out = WIDTH'(A < B);
      default: alu_out = '0;
    endcase
  end

  alu_iterative_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .start    (core_start),
    .is_div   (cls == CLS_DIV),
    .op_a     (A),
    .op_b     (B),
    .busy     (core_busy),
    .done     (core_done),
    .acc_next (core_acc),
    .quo_next (core_quo)
  );

  // The accumulator carries the product for MUL and the remainder for REMU.
  assign iter_res = ((op_q == OP_MUL) || (op_q == OP_REMU)) ? core_acc : core_quo;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      op_q     <= OP_AND;
      Result   <= '0;
      Zero     <= 1'b0;
      Error    <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= Control;
            Error <= (cls == CLS_ILLEGAL);
            case (cls)
              CLS_MUL: state <= ST_MUL;
              CLS_DIV: state <= ST_DIV;
              default: begin
                // Unknown opcodes fall through here with alu_out = 0, hence Zero = 1.
                state    <= ST_DONE;
                Result   <= alu_out;
                Zero     <= (alu_out == '0);
                OutValid <= 1'b1;
              end
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_done) begin
            state    <= ST_DONE;
            Result   <= iter_res;
            Zero     <= (iter_res == '0);
            OutValid <= 1'b1;
          end else if (!core_busy) begin
            // Core idle without reporting done: drop the operation instead of hanging.
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (OutReady) begin
            state    <= ST_IDLE;
            OutValid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench: a WIDTH=32 and a WIDTH=8 instance run the same scenarios in
// lockstep, each with its own operands and hand-computed expectations.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ctl = 4'h0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic        rdy32, z32, e32, ov32;
  logic        rdy8, z8, e8, ov8;

  int n_cmp = 0;
  int n_bad = 0;
  int lat32, lat8;
  bit rdy_seen;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(32)) dut32 (
    .CLOCK(clk), .RESET_N(rst_n), .Control(ctl), .A(a32), .B(b32),
    .InValid(iv), .InReady(rdy32), .Result(res32), .Zero(z32), .Error(e32),
    .OutValid(ov32), .OutReady(ordy)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .CLOCK(clk), .RESET_N(rst_n), .Control(ctl), .A(a8), .B(b8),
    .InValid(iv), .InReady(rdy8), .Result(res8), .Zero(z8), .Error(e8),
    .OutValid(ov8), .OutReady(ordy)
  );

  // Accepts one request on both instances and waits (bounded) until each shows
  // OutValid; latency counts the cycle right after the accept edge as 1.
  task automatic issue(input logic [3:0] op, input logic [31:0] x32, input logic [31:0] y32,
                       input logic [7:0] x8, input logic [7:0] y8, input bit pulse);
    @(negedge clk);
    ctl = op; a32 = x32; b32 = y32; a8 = x8; b8 = y8; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; ctl = 4'hF; a32 = ~x32; b32 = ~y32; a8 = ~x8; b8 = ~y8;
    lat32 = 0; lat8 = 0; rdy_seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (ov32 && lat32 == 0) lat32 = c;
      if (ov8 && lat8 == 0) lat8 = c;
      if ((!ov32 && rdy32) || (!ov8 && rdy8)) rdy_seen = 1'b1;
      if (lat32 != 0 && lat8 != 0) break;
      if (pulse) iv = ~iv;
      @(posedge clk); #1;
    end
    iv = 1'b0;
  endtask

  task automatic take();
    @(negedge clk); ordy = 1'b1;
    @(posedge clk); #1; ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({rdy32, ov32, res32, z32, e32} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset32 got rdy=%b ov=%b res=%h z=%b e=%b", rdy32, ov32, res32, z32, e32); end
    n_cmp++; if ({rdy8, ov8, res8, z8, e8} !== {1'b1, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset8 got rdy=%b ov=%b res=%h z=%b e=%b", rdy8, ov8, res8, z8, e8); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 8'h7F, 8'h1, 1'b0);
    n_cmp++; if ({res32, z32, e32} !== {32'h8000_0000, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL add32 got res=%h z=%b e=%b want 80000000/0/0", res32, z32, e32); end
    n_cmp++; if ({res8, z8, e8} !== {8'h80, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL add8 got res=%h z=%b e=%b want 80/0/0", res8, z8, e8); end
    n_cmp++; if (lat32 !== 1 || lat8 !== 1) begin
      n_bad++; $display("FAIL add_latency got %0d/%0d want 1/1", lat32, lat8); end
    take();
    issue(OP_SUB, 32'd5, 32'd5, 8'd5, 8'd5, 1'b0);
    n_cmp++; if ({res32, z32, res8, z8} !== {32'h0, 1'b1, 8'h0, 1'b1}) begin
      n_bad++; $display("FAIL sub_zero got %h/%b %h/%b want 0/1 0/1", res32, z32, res8, z8); end
    take();
  endtask

  task automatic test_logic_compare();
    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 8'hF0, 8'h3C, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'hF000_F000, 8'h30}) begin
      n_bad++; $display("FAIL and got %h %h want f000f000 30", res32, res8); end
    take();
    issue(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 8'hF0, 8'h3C, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'hFFF0_FFF0, 8'hFC}) begin
      n_bad++; $display("FAIL or got %h %h want fff0fff0 fc", res32, res8); end
    take();
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, 8'hFF, 8'h1, 1'b0);
    n_cmp++; if ({res32, z32, res8, z8} !== {32'h1, 1'b0, 8'h1, 1'b0}) begin
      n_bad++; $display("FAIL slt got %h/%b %h/%b want 1/0 1/0", res32, z32, res8, z8); end
    take();
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 8'hFF, 8'h1, 1'b0);
    n_cmp++; if ({res32, z32, res8, z8} !== {32'h0, 1'b1, 8'h0, 1'b1}) begin
      n_bad++; $display("FAIL sltu got %h/%b %h/%b want 0/1 0/1", res32, z32, res8, z8); end
    take();
  endtask

  task automatic test_shifts();
    issue(OP_SRA, 32'h8000_0000, 32'h24, 8'h80, 8'h24, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'hF800_0000, 8'hF8}) begin
      n_bad++; $display("FAIL sra got %h %h want f8000000 f8", res32, res8); end
    take();
    issue(OP_SRL, 32'h8000_0000, 32'h24, 8'h80, 8'h24, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'h0800_0000, 8'h08}) begin
      n_bad++; $display("FAIL srl got %h %h want 08000000 08", res32, res8); end
    take();
    issue(OP_SLL, 32'h1, 32'h21, 8'h1, 8'h21, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'h2, 8'h2}) begin
      n_bad++; $display("FAIL sll got %h %h want 2 2", res32, res8); end
    take();
  endtask

  task automatic test_mul();
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0003, 8'h10, 8'h13, 1'b1);
    n_cmp++; if ({res32, z32} !== {32'h0003_0000, 1'b0}) begin
      n_bad++; $display("FAIL mul32 got %h/%b want 00030000/0", res32, z32); end
    n_cmp++; if (res8 !== 8'h30) begin
      n_bad++; $display("FAIL mul8 got %h want 30", res8); end
    n_cmp++; if (lat32 !== 33 || lat8 !== 9) begin
      n_bad++; $display("FAIL mul_latency got %0d/%0d want 33/9", lat32, lat8); end
    n_cmp++; if (rdy_seen !== 1'b0) begin
      n_bad++; $display("FAIL mul_inready got InReady high while busy, want low"); end
    take();
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 8'hFF, 8'd3, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'hFFFF_FFFD, 8'hFD}) begin
      n_bad++; $display("FAIL mul_neg got %h %h want fffffffd fd", res32, res8); end
    take();
  endtask

  task automatic test_div();
    issue(OP_DIVU, 32'd100, 32'd7, 8'd100, 8'd7, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'd14, 8'd14}) begin
      n_bad++; $display("FAIL divu got %0d %0d want 14 14", res32, res8); end
    n_cmp++; if (lat32 !== 33 || lat8 !== 9) begin
      n_bad++; $display("FAIL div_latency got %0d/%0d want 33/9", lat32, lat8); end
    take();
    issue(OP_REMU, 32'd100, 32'd7, 8'd100, 8'd7, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'd2, 8'd2}) begin
      n_bad++; $display("FAIL remu got %0d %0d want 2 2", res32, res8); end
    take();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 8'hFF, 8'h10, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'h0FFF_FFFF, 8'h0F}) begin
      n_bad++; $display("FAIL divu_big got %h %h want 0fffffff 0f", res32, res8); end
    take();
    issue(OP_DIVU, 32'h1234_5678, 32'h0, 8'h5A, 8'h0, 1'b0);
    n_cmp++; if ({res32, e32, res8, e8} !== {32'hFFFF_FFFF, 1'b0, 8'hFF, 1'b0}) begin
      n_bad++; $display("FAIL divu_by0 got %h/%b %h/%b want ffffffff/0 ff/0", res32, e32, res8, e8); end
    n_cmp++; if (lat32 !== 33 || lat8 !== 9) begin
      n_bad++; $display("FAIL div0_latency got %0d/%0d want 33/9", lat32, lat8); end
    take();
    issue(OP_REMU, 32'd9, 32'd0, 8'd9, 8'd0, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'd9, 8'd9}) begin
      n_bad++; $display("FAIL remu_by0 got %0d %0d want 9 9", res32, res8); end
    take();
  endtask

  task automatic test_hold();
    issue(OP_ADD, 32'd3, 32'd4, 8'd3, 8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({ov32, rdy32, res32, z32, e32, ov8, rdy8, res8, z8, e8} !==
                   {1'b1, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL hold cycle %0d got ov=%b rdy=%b res=%h / ov=%b rdy=%b res=%h",
                          i, ov32, rdy32, res32, ov8, rdy8, res8); end
    end
    take();
  endtask

  task automatic test_error();
    issue(4'b1111, 32'h1234, 32'h5678, 8'h12, 8'h34, 1'b0);
    n_cmp++; if ({res32, z32, e32, res8, z8, e8} !== {32'h0, 1'b1, 1'b1, 8'h0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL illegal got %h/%b/%b %h/%b/%b want 0/1/1", res32, z32, e32, res8, z8, e8); end
    n_cmp++; if (lat32 !== 1 || lat8 !== 1) begin
      n_bad++; $display("FAIL illegal_latency got %0d/%0d want 1/1", lat32, lat8); end
    take();
    issue(OP_ADD, 32'd1, 32'd1, 8'd1, 8'd1, 1'b0);
    n_cmp++; if ({res32, e32, res8, e8} !== {32'd2, 1'b0, 8'd2, 1'b0}) begin
      n_bad++; $display("FAIL error_clear got %h/%b %h/%b want 2/0 2/0", res32, e32, res8, e8); end
    take();
  endtask

  task automatic test_back_to_back();
    issue(OP_ADD, 32'd10, 32'd20, 8'd10, 8'd20, 1'b0);
    take();
    n_cmp++; if ({rdy32, ov32, rdy8, ov8} !== 4'b1010) begin
      n_bad++; $display("FAIL after_take got rdy/ov %b%b %b%b want 10 10", rdy32, ov32, rdy8, ov8); end
    issue(OP_SUB, 32'd20, 32'd30, 8'd20, 8'd30, 1'b0);
    n_cmp++; if ({res32, res8, lat32[7:0], lat8[7:0]} !== {32'hFFFF_FFF6, 8'hF6, 8'd1, 8'd1}) begin
      n_bad++; $display("FAIL back_to_back got %h %h lat %0d/%0d want fffffff6 f6 1/1",
                        res32, res8, lat32, lat8); end
    take();
    // OutReady with nothing pending must not change anything.
    @(negedge clk); ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1; ordy = 1'b0;
    n_cmp++; if ({rdy32, ov32, rdy8, ov8} !== 4'b1010) begin
      n_bad++; $display("FAIL idle_outready got rdy/ov %b%b %b%b want 10 10", rdy32, ov32, rdy8, ov8); end
  endtask

  task automatic test_reset_mid_div();
    bit ov_seen;
    @(negedge clk);
    ctl = OP_DIVU; a32 = 32'd100; b32 = 32'd7; a8 = 8'd100; b8 = 8'd7; iv = 1'b1;
    @(posedge clk); #1; iv = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({rdy32, ov32, rdy8, ov8} !== 4'b1010) begin
      n_bad++; $display("FAIL reset_mid_div got rdy/ov %b%b %b%b want 10 10", rdy32, ov32, rdy8, ov8); end
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32 || ov8) ov_seen = 1'b1;
    end
    n_cmp++; if (ov_seen !== 1'b0) begin
      n_bad++; $display("FAIL reset_discard got OutValid after reset, want none"); end
    issue(OP_DIVU, 32'd100, 32'd7, 8'd100, 8'd7, 1'b0);
    n_cmp++; if ({res32, res8} !== {32'd14, 8'd14}) begin
      n_bad++; $display("FAIL div_after_reset got %0d %0d want 14 14", res32, res8); end
    take();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_compare();
    test_shifts();
    test_mul();
    test_div();
    test_hold();
    test_error();
    test_back_to_back();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
